// File: rtl/mult_div_unit_if.sv
// ============================================================================
// Module  : mult_div_unit_if
// Purpose : Pipeline-side handshake and result bus of the multiply/divide unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             done;
  logic             div_zero;

  modport master (
    output start, op, a, b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, stall, done, div_zero
  );

  modport slave (
    input  start, op, a, b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, stall, done, div_zero
  );
endinterface

`default_nettype wire

// File: rtl/mult_div_unit.sv
// ============================================================================
// Module  : mult_div_unit
// Purpose : Iterative MULT/MULTU/DIV/DIVU with HI/LO, one bit per cycle.
//           Define MDU_EARLY_OUT_EN to bypass CALC for zero operands.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  mult_div_unit_if.slave  bus
);
  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_count;
  logic                 r_is_div;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic                 r_b_zero;
  logic [WIDTH-1:0]     r_opnd;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_div_zero;

  logic                 w_sign_a;
  logic                 w_sign_b;
  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic                 w_early;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_mul_next;
  logic [WIDTH:0]       w_shifted;
  logic                 w_ge;
  logic [WIDTH-1:0]     w_rem_next;
  logic [2*WIDTH-1:0]   w_div_next;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quo;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  always_comb begin
    w_sign_a = ~bus.op[0] & bus.a[WIDTH-1];
    w_sign_b = ~bus.op[0] & bus.b[WIDTH-1];
    w_mag_a  = w_sign_a ? -bus.a : bus.a;
    w_mag_b  = w_sign_b ? -bus.b : bus.b;
    w_early  = 1'b0;
`ifdef MDU_EARLY_OUT_EN
    w_early  = bus.op[1] ? (bus.b == '0) : ((bus.a == '0) || (bus.b == '0));
`else
    w_early  = 1'b0;
`endif

    // Shift-add: accumulator holds {partial product, remaining multiplier bits}
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

    // Restoring divide: accumulator holds {remainder, dividend/quotient bits}
    w_shifted  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_ge       = (w_shifted >= {1'b0, r_opnd});
    w_rem_next = w_ge ? WIDTH'(w_shifted - {1'b0, r_opnd}) : w_shifted[WIDTH-1:0];
    w_div_next = {w_rem_next, r_acc[WIDTH-2:0], w_ge};

    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quo    = r_acc[WIDTH-1:0];
    w_rem    = r_acc[2*WIDTH-1:WIDTH];
    w_fix_hi = r_is_div ? (r_neg_r ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = r_is_div ? (r_b_zero ? {WIDTH{1'b1}} : (r_neg_q ? -w_quo : w_quo))
                        : w_prod[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_is_div   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_b_zero   <= 1'b0;
      r_opnd     <= '0;
      r_acc      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.hi_we) r_hi <= bus.wdata;
          if (bus.lo_we) r_lo <= bus.wdata;
          if (bus.start && !bus.flush) begin
            r_is_div <= bus.op[1];
            r_neg_q  <= w_sign_a ^ w_sign_b;
            r_neg_r  <= w_sign_a;
            r_b_zero <= bus.op[1] && (bus.b == '0);
            r_opnd   <= bus.op[1] ? w_mag_b : w_mag_a;
            r_count  <= '0;
            if (w_early) begin
              // Preload the values the full iteration would have produced
              r_acc   <= bus.op[1] ? {w_mag_a, {WIDTH{1'b1}}} : '0;
              r_state <= S_FIX;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, (bus.op[1] ? w_mag_a : w_mag_b)};
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.flush) begin
            r_state <= S_IDLE;
          end else begin
            r_acc   <= r_is_div ? w_div_next : w_mul_next;
            r_count <= r_count + c_cnt_w'(1);
            if (r_count == c_last) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!bus.flush) begin
            r_hi       <= w_fix_hi;
            r_lo       <= w_fix_lo;
            r_done     <= 1'b1;
            r_div_zero <= r_b_zero;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.hi       = r_hi;
  assign bus.lo       = r_lo;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.stall    = (r_state != S_IDLE) | (bus.start & (r_state == S_IDLE) & ~bus.flush);
  assign bus.done     = r_done;
  assign bus.div_zero = r_div_zero;
endmodule

`default_nettype wire

// File: tb/tb_mult_div_unit.sv
// ============================================================================
// Module  : tb_mult_div_unit
// Purpose : Directed self-checking bench for mult_div_unit (WIDTH=32).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  localparam int c_full_lat  = 33;
  localparam int c_full_busy = 33;
`ifdef MDU_EARLY_OUT_EN
  localparam int c_zero_lat  = 1;
  localparam int c_zero_busy = 1;
`else
  localparam int c_zero_lat  = 33;
  localparam int c_zero_busy = 33;
`endif

  mult_div_unit_if #(.WIDTH(32)) mdu ();

  mult_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mdu)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int elat, input int ebusy);
    int lat;
    int bcnt;
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = o;
    mdu.a     = x;
    mdu.b     = y;
    #1;
    chk({tag, ".stall"}, mdu.stall, 1);
    @(posedge clk);
    lat  = 0;
    bcnt = 0;
    @(negedge clk);
    while (!mdu.done && lat < 100) begin
      if (mdu.busy) bcnt++;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    mdu.start = 1'b0;
    chk({tag, ".latency"}, lat, elat);
    chk({tag, ".busy_cycles"}, bcnt, ebusy);
    chk({tag, ".hi"}, mdu.hi, eh);
    chk({tag, ".lo"}, mdu.lo, el);
    chk({tag, ".div_zero"}, mdu.div_zero, edz);
    @(negedge clk);
    chk({tag, ".done_pulse"}, mdu.done, 0);
  endtask

  initial begin
    reset     = 1'b0;
    mdu.start = 1'b0;
    mdu.op    = 2'b00;
    mdu.a     = '0;
    mdu.b     = '0;
    mdu.flush = 1'b0;
    mdu.hi_we = 1'b0;
    mdu.lo_we = 1'b0;
    mdu.wdata = '0;
    repeat (2) @(negedge clk);
    chk("reset.hi", mdu.hi, 0);
    chk("reset.lo", mdu.lo, 0);
    chk("reset.busy", mdu.busy, 0);
    chk("reset.done", mdu.done, 0);
    chk("reset.div_zero", mdu.div_zero, 0);
    chk("reset.stall", mdu.stall, 0);
    reset = 1'b1;

    run_op("mult_neg",  2'b00, 32'hFFFFFFFD, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, c_full_lat, c_full_busy);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, c_full_lat, c_full_busy);
    run_op("div_m7_2",  2'b10, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, c_full_lat, c_full_busy);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 32'h2, 32'hE, 1'b0, c_full_lat, c_full_busy);
    run_op("div_minneg", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0, c_full_lat, c_full_busy);
    run_op("div_7_m2",  2'b10, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD, 1'b0, c_full_lat, c_full_busy);
    run_op("div_m5_0",  2'b10, 32'hFFFFFFFB, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, c_zero_lat, c_zero_busy);
    run_op("divu_5_0",  2'b11, 32'd5, 32'h0, 32'h5, 32'hFFFFFFFF, 1'b1, c_zero_lat, c_zero_busy);

    // Preload HI/LO, start a multiply, then abort it mid-flight
    @(negedge clk);
    mdu.hi_we = 1'b1;
    mdu.wdata = 32'h11;
    @(negedge clk);
    mdu.hi_we = 1'b0;
    mdu.lo_we = 1'b1;
    mdu.wdata = 32'h22;
    @(negedge clk);
    mdu.lo_we = 1'b0;
    chk("preload.hi", mdu.hi, 32'h11);
    chk("preload.lo", mdu.lo, 32'h22);
    mdu.start = 1'b1;
    mdu.op    = 2'b00;
    mdu.a     = 32'd3;
    mdu.b     = 32'd5;
    @(posedge clk);
    repeat (4) @(negedge clk);
    mdu.hi_we = 1'b1;
    mdu.wdata = 32'h99;
    @(negedge clk);
    mdu.hi_we = 1'b0;
    chk("busy_hi_we.hi", mdu.hi, 32'h11);
    repeat (4) @(negedge clk);
    chk("pre_flush.busy", mdu.busy, 1);
    mdu.flush = 1'b1;
    mdu.start = 1'b0;
    @(negedge clk);
    mdu.flush = 1'b0;
    chk("flush.busy", mdu.busy, 0);
    chk("flush.done", mdu.done, 0);
    chk("flush.hi", mdu.hi, 32'h11);
    chk("flush.lo", mdu.lo, 32'h22);
    @(negedge clk);
    chk("flush.done_later", mdu.done, 0);

    mdu.start = 1'b1;
    mdu.flush = 1'b1;
    #1;
    chk("flush_start.stall", mdu.stall, 0);
    @(negedge clk);
    chk("flush_start.busy", mdu.busy, 0);
    mdu.start = 1'b0;
    mdu.flush = 1'b0;

    // Asynchronous reset in the middle of an operation
    @(negedge clk);
    mdu.start = 1'b1;
    mdu.op    = 2'b00;
    mdu.a     = 32'd3;
    mdu.b     = 32'd5;
    @(posedge clk);
    repeat (4) @(negedge clk);
    mdu.start = 1'b0;
    reset     = 1'b0;
    #1;
    chk("mid_reset.hi", mdu.hi, 0);
    chk("mid_reset.lo", mdu.lo, 0);
    chk("mid_reset.busy", mdu.busy, 0);
    chk("mid_reset.done", mdu.done, 0);
    chk("mid_reset.div_zero", mdu.div_zero, 0);
    chk("mid_reset.stall", mdu.stall, 0);
    @(negedge clk);
    reset = 1'b1;

    run_op("multu_shift", 2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, c_full_lat, c_full_busy);
    run_op("mult_zero",   2'b00, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 1'b0, c_zero_lat, c_zero_busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
